// File: rtl/tff_pkg.sv
// Shared constants and helpers for the toggle-flop up/down counter.
// Latency: none, pure functions and constants.
// Backpressure: not applicable.
package tff_pkg;

   // Encoding of the UP input.
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Helpers work on a fixed maximum width; callers size-cast in and out,
   // so the counter supports WIDTH up to MAX_W.
   localparam int MAX_W = 64;

   // Toggle request that moves the current state q to target d.
   function automatic logic [MAX_W-1:0] tff_toggle_vec(
      input logic [MAX_W-1:0] q,
      input logic [MAX_W-1:0] d
   );
      return q ^ d;
   endfunction

   // Running AND of the lower-order bits: p[0]=1, p[i]=&v[i-1:0].
   // Fed Q it gives the increment toggle chain, fed ~Q the decrement chain.
   function automatic logic [MAX_W-1:0] prefix_and(input logic [MAX_W-1:0] v);
      logic [MAX_W-1:0] p;
      p[0] = 1'b1;
      for (int i = 1; i < MAX_W; i++) begin
         p[i] = p[i-1] & v[i-1];
      end
      return p;
   endfunction

endpackage

// File: rtl/tff_updown_counter_if.sv
// Control/status bundle between a counter user and the counter.
// Latency: wires only.
// Backpressure: none; the counter accepts a request on every edge.
interface tff_updown_counter_if #(
   parameter int WIDTH = 8
);
   logic             E;
   logic             UP;
   logic             CLR;
   logic             LD;
   logic [WIDTH-1:0] D;
   logic             OVF_ACK;
   logic [WIDTH-1:0] Q;
   logic             TC;
   logic             OVF;

   modport master (output E, UP, CLR, LD, D, OVF_ACK, input Q, TC, OVF);
   modport slave  (input E, UP, CLR, LD, D, OVF_ACK, output Q, TC, OVF);
endinterface

// File: rtl/tff_cell.sv
// One toggle flip-flop state bit: Q flips on a rising C edge when T is high.
// Latency: 1 cycle from T to Q.
// Backpressure: none.
module tff_cell #(
   parameter logic INIT = 1'b0
) (
   input  logic C,
   input  logic R,
   input  logic T,
   output logic Q
);

   // Toggle state; async active-low reset forces the INIT value.
   always_ff @(posedge C or negedge R) begin
      if (!R) Q <= INIT;
      else    Q <= Q ^ T;
   end

endmodule

// File: rtl/tff_updown_counter.sv
// Up/down counter built purely from toggle cells; load/clear/saturate are toggle requests.
// Latency: 1 cycle request-to-Q; TC is combinational from Q and UP.
// Backpressure: none; every edge acts on CLR > LD > E > hold.
module tff_updown_counter
   import tff_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter bit               SATURATE = 1'b0,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic                  C,
   input  logic                  R,
   tff_updown_counter_if.slave   bus
);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] t_vec;
   logic [WIDTH-1:0] t_up;
   logic [WIDTH-1:0] t_dn;
   logic [WIDTH-1:0] t_clr;
   logic [WIDTH-1:0] t_ld;
   logic             tc;
   logic             set_event;
   logic             ovf;

   // Terminal count depends on the direction being requested right now.
   assign tc = (bus.UP == DIR_UP) ? (&q) : ((bus.UP == DIR_DN) & ~(|q));

   // Carry chain for up, borrow chain for down, and the XOR-with-target toggles.
   assign t_up  = WIDTH'(prefix_and(MAX_W'(q)));
   assign t_dn  = WIDTH'(prefix_and(MAX_W'(~q)));
   assign t_clr = WIDTH'(tff_toggle_vec(MAX_W'(q), MAX_W'(RST_VAL)));
   assign t_ld  = WIDTH'(tff_toggle_vec(MAX_W'(q), MAX_W'(bus.D)));

   // Toggle select with CLR > LD > count > hold; a count at TC is a wrap or a saturate attempt.
   always_comb begin
      t_vec     = '0;
      set_event = 1'b0;
      if (bus.CLR) begin
         t_vec = t_clr;
      end else if (bus.LD) begin
         t_vec = t_ld;
      end else if (bus.E) begin
         set_event = tc;
         if (!(SATURATE && tc)) begin
            t_vec = (bus.UP == DIR_UP) ? t_up : t_dn;
         end
      end
   end

   // State bits, each reset to its own RST_VAL bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell #(
         .INIT (RST_VAL[i])
      ) u_cell (
         .C (C),
         .R (R),
         .T (t_vec[i]),
         .Q (q[i])
      );
   end

   // Sticky overflow flag; a new event beats a same-cycle acknowledge.
   always_ff @(posedge C or negedge R) begin
      if (!R) ovf <= 1'b0;
      else    ovf <= (ovf & ~bus.OVF_ACK) | set_event;
   end

   assign bus.Q   = q;
   assign bus.TC  = tc;
   assign bus.OVF = ovf;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed checks on two 4-bit counters (wrap and saturate) plus a random
// run of an 8-bit counter against a plain arithmetic reference.
module tb_tff_updown_counter;

   logic C;
   logic R;

   int vectors = 0;
   int errors  = 0;

   tff_updown_counter_if #(.WIDTH(4)) ba ();
   tff_updown_counter_if #(.WIDTH(4)) bs ();
   tff_updown_counter_if #(.WIDTH(8)) bw ();

   tff_updown_counter #(.WIDTH(4), .SATURATE(1'b0), .RST_VAL(4'h5)) dut_a (
      .C   (C),
      .R   (R),
      .bus (ba)
   );

   tff_updown_counter #(.WIDTH(4), .SATURATE(1'b1), .RST_VAL(4'h5)) dut_s (
      .C   (C),
      .R   (R),
      .bus (bs)
   );

   tff_updown_counter #(.WIDTH(8), .SATURATE(1'b0), .RST_VAL(8'h00)) dut_w (
      .C   (C),
      .R   (R),
      .bus (bw)
   );

   initial begin
      C = 1'b0;
      forever #5 C = ~C;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic set_a(input logic e, input logic up, input logic clr,
                        input logic ld, input logic [3:0] d, input logic ack);
      ba.E = e; ba.UP = up; ba.CLR = clr; ba.LD = ld; ba.D = d; ba.OVF_ACK = ack;
   endtask

   task automatic set_s(input logic e, input logic up, input logic clr,
                        input logic ld, input logic [3:0] d, input logic ack);
      bs.E = e; bs.UP = up; bs.CLR = clr; bs.LD = ld; bs.D = d; bs.OVF_ACK = ack;
   endtask

   logic [7:0] m_q;
   logic       m_ovf;
   logic       m_set;

   initial begin
      R = 1'b0;
      set_a(0, 1, 0, 0, 4'h0, 0);
      set_s(0, 1, 0, 0, 4'h0, 0);
      bw.E = 0; bw.UP = 1; bw.CLR = 0; bw.LD = 0; bw.D = '0; bw.OVF_ACK = 0;

      // Reset state and count out of reset
      tick(); tick();
      check("rst_q", 8'(ba.Q), 8'h5);
      check("rst_ovf", 8'(ba.OVF), 8'h0);
      R = 1'b1;
      set_a(1, 1, 0, 0, 4'h0, 0);
      tick();
      check("rel_q6", 8'(ba.Q), 8'h6);
      tick();
      check("cnt_q7", 8'(ba.Q), 8'h7);
      // Reset mid-cycle takes effect without a clock edge
      #2 R = 1'b0;
      #1;
      check("async_rst_q", 8'(ba.Q), 8'h5);
      check("async_rst_ovf", 8'(ba.OVF), 8'h0);
      #1 R = 1'b1;
      tick();
      check("rerel_q6", 8'(ba.Q), 8'h6);

      // Up wrap
      set_a(0, 1, 0, 1, 4'hE, 0);
      tick();
      check("ld_e", 8'(ba.Q), 8'hE);
      set_a(1, 1, 0, 0, 4'h0, 0);
      #1;
      check("tc_at_e", 8'(ba.TC), 8'h0);
      tick();
      check("up_f", 8'(ba.Q), 8'hF);
      check("tc_at_f", 8'(ba.TC), 8'h1);
      check("ovf_before_wrap", 8'(ba.OVF), 8'h0);
      tick();
      check("wrap_0", 8'(ba.Q), 8'h0);
      check("wrap_ovf", 8'(ba.OVF), 8'h1);

      // Ack racing a new wrap: set wins, then a lone ack clears
      set_a(0, 1, 0, 1, 4'hF, 0);
      tick();
      check("ld_f_ovf_sticky", 8'(ba.OVF), 8'h1);
      set_a(1, 1, 0, 0, 4'h0, 1);
      tick();
      check("race_q", 8'(ba.Q), 8'h0);
      check("race_ovf", 8'(ba.OVF), 8'h1);
      set_a(0, 1, 0, 0, 4'h0, 1);
      tick();
      check("ack_ovf", 8'(ba.OVF), 8'h0);
      check("hold_q", 8'(ba.Q), 8'h0);

      // Priority CLR > LD > count
      set_a(0, 1, 0, 1, 4'h3, 0);
      tick();
      check("ld_3", 8'(ba.Q), 8'h3);
      set_a(1, 1, 1, 1, 4'hA, 0);
      tick();
      check("clr_wins", 8'(ba.Q), 8'h5);
      check("clr_no_ovf", 8'(ba.OVF), 8'h0);
      set_a(1, 1, 0, 1, 4'hA, 0);
      tick();
      check("ld_wins", 8'(ba.Q), 8'hA);
      set_a(1, 0, 0, 0, 4'h0, 0);
      tick();
      check("down_9", 8'(ba.Q), 8'h9);

      // Down wrap, then CLR leaves OVF alone
      set_a(0, 0, 0, 1, 4'h0, 0);
      tick();
      set_a(1, 0, 0, 0, 4'h0, 0);
      #1;
      check("tc_dn_at_0", 8'(ba.TC), 8'h1);
      tick();
      check("dn_wrap_f", 8'(ba.Q), 8'hF);
      check("dn_wrap_ovf", 8'(ba.OVF), 8'h1);
      set_a(0, 0, 1, 0, 4'h0, 0);
      tick();
      check("clr_q", 8'(ba.Q), 8'h5);
      check("clr_keeps_ovf", 8'(ba.OVF), 8'h1);
      set_a(0, 1, 0, 0, 4'h0, 0);

      // Down saturate
      set_s(0, 0, 0, 1, 4'h1, 0);
      tick();
      check("s_ld_1", 8'(bs.Q), 8'h1);
      set_s(1, 0, 0, 0, 4'h0, 0);
      tick();
      check("s_dn_0", 8'(bs.Q), 8'h0);
      check("s_ovf_first", 8'(bs.OVF), 8'h0);
      check("s_tc", 8'(bs.TC), 8'h1);
      check("s_t_zero", 8'(dut_s.t_vec), 8'h0);
      tick();
      check("s_hold0_a", 8'(bs.Q), 8'h0);
      check("s_ovf_set", 8'(bs.OVF), 8'h1);
      tick();
      check("s_hold0_b", 8'(bs.Q), 8'h0);
      check("s_ovf_stay", 8'(bs.OVF), 8'h1);

      // Up saturate after acknowledging
      set_s(0, 1, 0, 0, 4'h0, 1);
      tick();
      check("s_ack", 8'(bs.OVF), 8'h0);
      set_s(0, 1, 0, 1, 4'hE, 0);
      tick();
      set_s(1, 1, 0, 0, 4'h0, 0);
      tick();
      check("s_up_f", 8'(bs.Q), 8'hF);
      check("s_up_ovf0", 8'(bs.OVF), 8'h0);
      tick();
      check("s_up_hold", 8'(bs.Q), 8'hF);
      check("s_up_ovf1", 8'(bs.OVF), 8'h1);
      set_s(0, 1, 0, 0, 4'h0, 0);

      // Random run of the 8-bit counter against an arithmetic reference
      m_q   = 8'h00;
      m_ovf = 1'b0;
      check("w_start_q", bw.Q, m_q);
      for (int n = 0; n < 2000; n++) begin
         bw.E       = ($urandom_range(3) != 0);
         bw.UP      = 1'($urandom_range(1));
         bw.CLR     = ($urandom_range(15) == 0);
         bw.LD      = ($urandom_range(7) == 0);
         bw.D       = 8'($urandom_range(255));
         bw.OVF_ACK = ($urandom_range(3) == 0);
         #1;
         check("w_tc", 8'(bw.TC), 8'(bw.UP ? (m_q == 8'hFF) : (m_q == 8'h00)));
         m_set = 1'b0;
         if (bw.CLR) begin
            m_q = 8'h00;
         end else if (bw.LD) begin
            m_q = bw.D;
         end else if (bw.E) begin
            if (bw.UP) begin
               m_set = (m_q == 8'hFF);
               m_q   = m_q + 8'h01;
            end else begin
               m_set = (m_q == 8'h00);
               m_q   = m_q - 8'h01;
            end
         end
         m_ovf = (m_ovf & ~bw.OVF_ACK) | m_set;
         tick();
         check("w_q", bw.Q, m_q);
         check("w_ovf", 8'(bw.OVF), 8'(m_ovf));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
